// File: rtl/pcm_feeder.sv
// rtl/pcm_feeder.sv - PCM sample FIFO and prescaled feeder to DAC; optional PCM_FEEDER_VOLUME_EN adds vol_i shift
module pcm_feeder #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic               wr_i,
    input  logic [7:0]         wr_data_i,
    output logic               full_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               underrun_o,
    output logic               overflow_o,
    input  logic               clr_flags_i,
`ifdef PCM_FEEDER_VOLUME_EN
    input  logic [2:0]         vol_i,
`endif
    output logic               tick_o,
    output logic [7:0]         dac_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] ONE_L   = (FIFO_AW+1)'(1);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_q;
    logic [DIV_W-1:0]   count_q;

    logic               tick_int;
    logic               empty;
    logic               pop;
    logic               push;
    logic signed [7:0]  head;
    logic signed [7:0]  scaled;
    logic [7:0]         play_data;

    assign tick_int = en_i && (count_q == '0);
    assign empty    = (level_q == '0);
    assign pop      = tick_int && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign push     = wr_i && ((level_q != DEPTH_L) || pop);

    assign head = $signed(mem[rd_ptr]);
`ifdef PCM_FEEDER_VOLUME_EN
    assign scaled = head >>> vol_i;
`else
    assign scaled = head;
`endif
    assign play_data = scaled ^ 8'h80;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (!en_i) begin
            count_q <= '0;
        end else if (count_q == '0) begin
            count_q <= div_i;
        end else begin
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + ONE_L;
                2'b01:   level_q <= level_q - ONE_L;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dac_o  <= 8'h80;
            tick_o <= 1'b0;
        end else begin
            tick_o <= tick_int;
            if (tick_int) begin
                dac_o <= pop ? play_data : 8'h80;
            end else if (!en_i) begin
                dac_o <= 8'h80;
            end
        end
    end

    // Set has priority over clear so no event is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (tick_int && empty) begin
                underrun_o <= 1'b1;
            end else if (clr_flags_i) begin
                underrun_o <= 1'b0;
            end
            if (wr_i && !push) begin
                overflow_o <= 1'b1;
            end else if (clr_flags_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    assign level_o = level_q;
    assign full_o  = level_q[FIFO_AW];

endmodule

// File: tb/tb_pcm_feeder.sv
// tb/tb_pcm_feeder.sv - directed self-checking bench for pcm_feeder
module tb_pcm_feeder;

    localparam int DIV_W   = 16;
    localparam int FIFO_AW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [DIV_W-1:0]   div;
    logic               wr;
    logic [7:0]         wr_data;
    logic               full;
    logic [FIFO_AW:0]   level;
    logic               underrun;
    logic               overflow;
    logic               clr_flags;
    logic               tick;
    logic [7:0]         dac;
`ifdef PCM_FEEDER_VOLUME_EN
    logic [2:0]         vol;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcm_feeder #(.DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .div_i       (div),
        .wr_i        (wr),
        .wr_data_i   (wr_data),
        .full_o      (full),
        .level_o     (level),
        .underrun_o  (underrun),
        .overflow_o  (overflow),
        .clr_flags_i (clr_flags),
`ifdef PCM_FEEDER_VOLUME_EN
        .vol_i       (vol),
`endif
        .tick_o      (tick),
        .dac_o       (dac)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t2_in  [3] = '{8'h81, 8'h00, 8'h7F};
    logic [7:0] t2_dac [4] = '{8'h01, 8'h80, 8'hFF, 8'h80};
    logic [4:0] t2_lvl [4] = '{5'd2, 5'd1, 5'd0, 5'd0};

    initial begin
        rst = 1'b1; en = 1'b0; div = '0; wr = 1'b0; wr_data = '0; clr_flags = 1'b0;
`ifdef PCM_FEEDER_VOLUME_EN
        vol = 3'd0;
`endif
        step();
        step();
        check("rst_dac", dac, 8'h80);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tick", tick, 0);

        // empty FIFO, period 4
        rst = 1'b0; en = 1'b1; div = 16'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            check("t1_tick", tick, (i % 4) == 0);
            check("t1_dac", dac, 8'h80);
        end
        check("t1_underrun", underrun, 1);
        en = 1'b0;
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("t1_clr", underrun, 0);

        // three samples, period 10
        for (int k = 0; k < 3; k++) begin
            wr = 1'b1; wr_data = t2_in[k];
            step();
        end
        wr = 1'b0;
        check("t2_level0", level, 3);
        div = 16'd9; en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i % 10 == 0) begin
                check("t2_tick", tick, 1);
                check("t2_dac", dac, t2_dac[i/10]);
                check("t2_level", level, t2_lvl[i/10]);
                if (i == 20) check("t2_no_underrun", underrun, 0);
            end else begin
                check("t2_notick", tick, 0);
            end
        end
        check("t2_underrun", underrun, 1);
        en = 1'b0;
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;

        // enable falling mid-playback keeps FIFO contents
        wr = 1'b1; wr_data = 8'h10; step();
        wr_data = 8'h20; step();
        wr = 1'b0; en = 1'b1; div = 16'd7;
        step();
        check("ef_dac0", dac, 8'h90);
        en = 1'b0;
        step();
        check("ef_dac_off", dac, 8'h80);
        check("ef_level", level, 1);
        check("ef_tick", tick, 0);
        en = 1'b1;
        step();
        check("ef_tick_re", tick, 1);
        check("ef_dac1", dac, 8'hA0);
        en = 1'b0;

        // overfill while disabled
        for (int k = 0; k < 17; k++) begin
            wr = 1'b1; wr_data = (k < 16) ? 8'(8'h10 + k) : 8'h77;
            step();
            if (k == 15) begin
                check("t3_full", full, 1);
                check("t3_level16", level, 16);
                check("t3_no_ovf", overflow, 0);
            end
        end
        check("t3_ovf", overflow, 1);
        check("t3_level_keep", level, 16);

        // write while full on a tick cycle is accepted
        wr = 1'b1; wr_data = 8'h33; en = 1'b1; div = 16'd1;
        step();
        wr = 1'b0;
        check("t4_tick", tick, 1);
        check("t4_dac", dac, 8'h90);
        check("t4_level", level, 16);
        check("t4_full", full, 1);
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i % 2 == 0) begin
                check("t4_tick_n", tick, 1);
                check("t4_dac_n", dac, (i < 32) ? ((8'h10 + i/2) ^ 8'h80) : 8'hB3);
                check("t4_level_n", level, 16 - i/2);
            end
        end
        check("t4_no_underrun", underrun, 0);
        step();
        clr_flags = 1'b1;
        step();
        check("t4_set_wins", underrun, 1);
        check("t4_ovf_clr", overflow, 0);
        step();
        clr_flags = 1'b0;
        check("t4_clr_und", underrun, 0);
        check("t4_clr_ovf", overflow, 0);
        en = 1'b0;
        step();

        // reset mid-playback with level 5
        for (int k = 0; k < 6; k++) begin
            wr = 1'b1; wr_data = 8'(8'h40 + k);
            step();
        end
        wr = 1'b0; en = 1'b1; div = 16'd3;
        step();
        check("t5_dac", dac, 8'hC0);
        check("t5_level5", level, 5);
        step();
        rst = 1'b1;
        step();
        check("t5_rst_dac", dac, 8'h80);
        check("t5_rst_level", level, 0);
        check("t5_rst_tick", tick, 0);
        rst = 1'b0; en = 1'b0;
        step();
        en = 1'b1;
        step();
        check("t5_empty_tick", tick, 1);
        check("t5_empty_dac", dac, 8'h80);
        check("t5_empty_und", underrun, 1);
        en = 1'b0; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;

        // write into empty FIFO on a tick: no bypass
        en = 1'b1; div = 16'd2; wr = 1'b1; wr_data = 8'h05;
        step();
        wr = 1'b0;
        check("t6_dac0", dac, 8'h80);
        check("t6_und", underrun, 1);
        check("t6_level1", level, 1);
        step();
        step();
        check("t6_notick", tick, 0);
        step();
        check("t6_tick", tick, 1);
        check("t6_dac1", dac, 8'h85);
        check("t6_level0", level, 0);
        en = 1'b0;
        step();

`ifdef PCM_FEEDER_VOLUME_EN
        wr = 1'b1; wr_data = 8'h80; step(); step();
        wr = 1'b0; en = 1'b1; div = 16'd0; vol = 3'd2;
        step();
        check("vol2", dac, 8'h60);
        vol = 3'd0;
        step();
        check("vol0", dac, 8'h00);
        en = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcm_feeder.md
# pcm_feeder

Sample-rate PCM feeder sitting directly upstream of the delta-sigma audio DAC. The CPU/bus side writes signed 8-bit samples into a small FIFO. A programmable prescaler pops one sample per sample period. Each popped sample is converted to excess-128 and held on `dac_o`, which drives the DAC input. On underrun or when disabled, the block outputs mid-scale silence, so the DAC never sees a DC step.

## Interface
- `DIV_W`, default 16: prescaler width.
- `FIFO_AW`, default 4: FIFO address width; depth = 2**FIFO_AW (16).

Ports:
- `clk_i`, input, 1: system clock; the DAC runs on the same clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `en_i`, input, 1: playback enable.
- `div_i`, input, DIV_W: sample period minus one, in `clk_i` cycles.
- `wr_i`, input, 1: write strobe, one sample per cycle.
- `wr_data_i`, input, 8: signed two's-complement sample.
- `full_o`, output, 1: FIFO holds 2**FIFO_AW entries.
- `level_o`, output, FIFO_AW+1: current FIFO occupancy.
- `underrun_o`, output, 1: sticky; a tick found the FIFO empty.
- `overflow_o`, output, 1: sticky; a write was dropped.
- `clr_flags_i`, input, 1: clears both sticky flags.
- `tick_o`, output, 1: one-cycle pulse, coincident with each `dac_o` update.
- `dac_o`, output, 8: excess-128 sample to the DAC input.

## Operation
Reset (`rst_i` high at a `clk_i` edge):
- `dac_o` = 8'h80
- `level_o` = 0 and FIFO pointers = 0
- `full_o` = 0, `underrun_o` = 0, `overflow_o` = 0
- `tick_o` = 0
- prescaler count = 0

Reset mid-playback discards all FIFO contents.

Prescaler:
- When `en_i` = 0: count is forced to 0 and no tick occurs.
- When `en_i` = 1 and count = 0: internal tick fires and count loads `div_i`.
- Otherwise: count decrements.
- The first tick occurs on the first enabled cycle. The sample period is `div_i`+1 cycles.
- A change to `div_i` takes effect at the next reload.

On a tick:
- FIFO non-empty: pop the head entry. `dac_o` ← sample XOR 8'h80 (−128→8'h00, 0→8'h80, +127→8'hFF).
- FIFO empty: `dac_o` ← 8'h80 and `underrun_o` is set.

On `en_i` falling, `dac_o` ← 8'h80 on the next cycle. FIFO contents are retained.

FIFO write (`wr_i` high):
- Accepted if `level_o` < depth, or if a pop occurs in the same cycle.
- Otherwise the sample is dropped and `overflow_o` is set.

Boundary cases:
- Write and pop in the same cycle: `level_o` is unchanged.
- Write into an empty FIFO on a tick cycle: no bypass. The tick underruns, and the written sample plays on the next tick.
- Pointers wrap modulo depth. `level_o` ranges 0..depth.
- `clr_flags_i` together with a new set event in the same cycle: the set wins.

## Timing
- Tick at cycle N → `dac_o` and `tick_o` registered at N+1. `tick_o` is high for exactly one cycle.
- Write at cycle N → `level_o`/`full_o` updated at N+1. The sample is eligible for a pop from a tick at N+1 onward.
- All outputs are registered. There is no combinational path from an input to an output.

## Configuration
- `PCM_FEEDER_VOLUME_EN` defined:
  - Adds input `vol_i` [2:0].
  - The popped sample is arithmetically right-shifted by `vol_i` before the XOR with 8'h80.
  - `vol_i` is sampled on the tick cycle.
  - Underrun and disabled outputs remain 8'h80.
- Not defined: `vol_i` does not exist and samples pass at unity gain.

## Test plan
- Reset, then `en_i`=1, `div_i`=3, FIFO empty → `tick_o` every 4 cycles, `dac_o` stays 8'h80, `underrun_o`=1 after the first tick.
- Write 8'h81, 8'h00, 8'h7F, then enable with `div_i`=9 → `dac_o` sequence 8'h01, 8'h80, 8'hFF, then 8'h80, with 10 cycles between updates and `level_o` 3→2→1→0.
- Write 17 samples while disabled → `full_o`=1, `level_o`=16, `overflow_o`=1, and the 17th sample is never played.
- With FIFO full, write on the tick cycle → write accepted and `level_o` stays 16. Assert `clr_flags_i` → both flags clear.
- Assert `rst_i` mid-playback with `level_o`=5 → next cycle `dac_o`=8'h80, `level_o`=0, no `tick_o`.
- With `PCM_FEEDER_VOLUME_EN` defined, `vol_i`=2 and sample 8'h80 (−128) → `dac_o`=8'h60. With `vol_i`=0 → `dac_o`=8'h00.
